// File: rtl/nem_ohmux_sel_ctrl_4i.sv
// Break-before-make select sequencer for the 4-input NEM-relay one-hot mux.
// Converts binary select requests into timed release/actuate relay sequences.
module nem_ohmux_sel_ctrl_4i #(
  parameter int unsigned RELEASE_CYC = 4,
  parameter int unsigned ACTUATE_CYC = 6,
  parameter int unsigned CNT_W       = 4
) (
  input  logic        CP,
  input  logic        RST,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic [1:0]  REQ_SEL,
  input  logic        REQ_OFF,
  output logic        S0,
  output logic        S1,
  output logic        S2,
  output logic        S3,
  output logic        SETTLED,
  output logic        CUR_EN,
  output logic [1:0]  CUR_SEL,
  output logic [15:0] ACT_CNT
);

  typedef enum logic [1:0] {
    ST_RELEASE,
    ST_ACTUATE,
    ST_IDLE
  } state_t;

  localparam logic [CNT_W-1:0] REL_LOAD = CNT_W'(RELEASE_CYC - 1);
  localparam logic [CNT_W-1:0] ACT_LOAD = CNT_W'(ACTUATE_CYC - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             pend_off;
  logic [1:0]       pend_sel;
  logic [3:0]       sel_q;

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    onehot = 4'b0001 << idx;
  endfunction

  assign S0        = sel_q[0];
  assign S1        = sel_q[1];
  assign S2        = sel_q[2];
  assign S3        = sel_q[3];
  assign REQ_READY = (state == ST_IDLE);
  assign SETTLED   = (state == ST_IDLE);

  // Reset enters RELEASE with an OFF request pending so a relay left closed
  // gets a full release interval before anything new is accepted.
  always_ff @(posedge CP) begin
    if (RST) begin
      state    <= ST_RELEASE;
      cnt      <= REL_LOAD;
      pend_off <= 1'b1;
      pend_sel <= '0;
      sel_q    <= '0;
      CUR_EN   <= 1'b0;
      CUR_SEL  <= '0;
      ACT_CNT  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (REQ_VALID) begin
            if (!REQ_OFF && !CUR_EN) begin
              state   <= ST_ACTUATE;
              sel_q   <= onehot(REQ_SEL);
              CUR_EN  <= 1'b1;
              CUR_SEL <= REQ_SEL;
              cnt     <= ACT_LOAD;
              if (ACT_CNT != '1) ACT_CNT <= ACT_CNT + 16'd1;
            end else if (REQ_OFF ? CUR_EN : (REQ_SEL != CUR_SEL)) begin
              state    <= ST_RELEASE;
              sel_q    <= '0;
              cnt      <= REL_LOAD;
              pend_off <= REQ_OFF;
              pend_sel <= REQ_SEL;
              CUR_EN   <= !REQ_OFF;
              CUR_SEL  <= REQ_SEL;
            end
          end
        end
        ST_RELEASE: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else if (pend_off) begin
            state <= ST_IDLE;
          end else begin
            state <= ST_ACTUATE;
            sel_q <= onehot(pend_sel);
            cnt   <= ACT_LOAD;
            if (ACT_CNT != '1) ACT_CNT <= ACT_CNT + 16'd1;
          end
        end
        ST_ACTUATE: begin
          if (cnt != '0) cnt <= cnt - CNT_W'(1);
          else           state <= ST_IDLE;
        end
        default: state <= ST_RELEASE;
      endcase
    end
  end

endmodule

// File: tb/tb_nem_ohmux_sel_ctrl_4i.sv
// Self-checking bench for nem_ohmux_sel_ctrl_4i: directed scenarios then random
// requests, compared against a per-cycle output schedule model.
module tb_nem_ohmux_sel_ctrl_4i;

  localparam int unsigned R = 4;
  localparam int unsigned A = 6;

  logic        CP = 1'b0;
  logic        RST = 1'b1;
  logic        REQ_VALID = 1'b0;
  logic        REQ_OFF = 1'b0;
  logic [1:0]  REQ_SEL = '0;
  logic        REQ_READY, S0, S1, S2, S3, SETTLED, CUR_EN;
  logic [1:0]  CUR_SEL;
  logic [15:0] ACT_CNT;

  nem_ohmux_sel_ctrl_4i #(
    .RELEASE_CYC(R),
    .ACTUATE_CYC(A),
    .CNT_W(4)
  ) dut (
    .CP(CP), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_SEL(REQ_SEL), .REQ_OFF(REQ_OFF),
    .S0(S0), .S1(S1), .S2(S2), .S3(S3),
    .SETTLED(SETTLED), .CUR_EN(CUR_EN), .CUR_SEL(CUR_SEL), .ACT_CNT(ACT_CNT)
  );

  always #5 CP = ~CP;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  // Model: expected S for each upcoming cycle; block is busy while non-empty.
  typedef struct {
    logic [3:0] s;
    bit         close;
  } slot_t;

  slot_t       plan[$];
  logic [3:0]  m_s   = '0;
  logic        m_en  = 1'b0;
  logic [1:0]  m_sel = '0;
  logic [15:0] m_act = '0;
  logic [3:0]  last_nz = '0;
  int unsigned zero_run = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  task automatic push_n(input logic [3:0] s, input int unsigned n);
    slot_t e;
    e.s = s;
    e.close = 1'b0;
    for (int unsigned i = 0; i < n; i++) plan.push_back(e);
  endtask

  task automatic model_edge();
    slot_t      e;
    logic [3:0] oh;
    oh = 4'b0001 << REQ_SEL;
    if (RST) begin
      m_s = '0; m_en = 1'b0; m_sel = '0; m_act = '0;
      plan.delete();
      push_n(4'b0000, R);
    end else if (plan.size() != 0) begin
      e = plan.pop_front();
      m_s = e.s;
      if (e.close) m_act = sat_inc(m_act);
    end else if (REQ_VALID) begin
      if (!REQ_OFF && m_en && REQ_SEL == m_sel) begin
      end else if (REQ_OFF && !m_en) begin
      end else if (!REQ_OFF && !m_en) begin
        m_s = oh; m_en = 1'b1; m_sel = REQ_SEL;
        m_act = sat_inc(m_act);
        push_n(oh, A);
      end else begin
        m_s = '0; m_en = !REQ_OFF; m_sel = REQ_SEL;
        if (REQ_OFF) begin
          push_n(4'b0000, R);
        end else begin
          push_n(4'b0000, R - 1);
          e.s = oh;
          e.close = 1'b1;
          plan.push_back(e);
          push_n(oh, A);
        end
      end
    end
  endtask

  task automatic check_all();
    logic [3:0] s;
    logic       idle;
    s = {S3, S2, S1, S0};
    idle = (plan.size() == 0);
    check("S", 32'(s), 32'(m_s));
    check("REQ_READY", 32'(REQ_READY), 32'(idle));
    check("SETTLED", 32'(SETTLED), 32'(idle));
    check("CUR_EN", 32'(CUR_EN), 32'(m_en));
    if (m_en) check("CUR_SEL", 32'(CUR_SEL), 32'(m_sel));
    check("ACT_CNT", 32'(ACT_CNT), 32'(m_act));
    check("onehot0", 32'($countones(s) <= 1), 32'd1);
    if (s != '0) begin
      if (last_nz != '0 && s != last_nz) check("bbm_gap", 32'(zero_run >= R), 32'd1);
      last_nz  = s;
      zero_run = 0;
    end else begin
      zero_run++;
    end
  endtask

  task automatic step(input logic rst, input logic v, input logic off, input logic [1:0] sel);
    RST = rst; REQ_VALID = v; REQ_OFF = off; REQ_SEL = sel;
    @(posedge CP);
    model_edge();
    @(negedge CP);
    check_all();
  endtask

  task automatic idle_n(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 2'd0);
  endtask

  initial begin
    step(1'b1, 1'b0, 1'b0, 2'd0);
    step(1'b1, 1'b0, 1'b0, 2'd0);
    idle_n(R + 1);

    step(1'b0, 1'b1, 1'b0, 2'd2);
    idle_n(A + 1);
    step(1'b0, 1'b1, 1'b0, 2'd1);
    idle_n(R + A + 1);
    step(1'b0, 1'b1, 1'b0, 2'd1);
    step(1'b0, 1'b1, 1'b0, 2'd1);
    step(1'b0, 1'b1, 1'b1, 2'd3);
    idle_n(R + 1);

    step(1'b0, 1'b1, 1'b0, 2'd3);
    for (int unsigned i = 0; i < A + 2; i++)
      step(1'b0, 1'b1, 1'b0, 2'($urandom_range(0, 3)));
    idle_n(3);

    step(1'b0, 1'b1, 1'b1, 2'd0);
    idle_n(R + 1);
    step(1'b0, 1'b1, 1'b0, 2'd0);
    idle_n(2);
    step(1'b1, 1'b0, 1'b0, 2'd0);
    idle_n(R + 1);

    // Pre-load the wear counter near its ceiling, then close three times.
    force dut.ACT_CNT = 16'hFFFE;
    m_act = 16'hFFFE;
    #1;
    release dut.ACT_CNT;
    for (int unsigned k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, 1'b0, 2'(k));
      idle_n(A + 1);
      step(1'b0, 1'b1, 1'b1, 2'd0);
      idle_n(R + 1);
    end

    for (int unsigned i = 0; i < 600; i++)
      step(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
